// File: rtl/memory_interface_if.sv
// Word-serial RAM bus between memory_interface (master) and the RAM (slave).
interface memory_interface_if #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] RAM_ADDR;
   logic                  RAM_RD;
   logic                  RAM_WR;
   logic [DATA_WIDTH-1:0] RAM_WDATA;
   logic [DATA_WIDTH-1:0] RAM_RDATA;
   logic                  RAM_READY;

   modport master (
      output RAM_ADDR, RAM_RD, RAM_WR, RAM_WDATA,
      input  RAM_RDATA, RAM_READY
   );

   modport slave (
      input  RAM_ADDR, RAM_RD, RAM_WR, RAM_WDATA,
      output RAM_RDATA, RAM_READY
   );
endinterface

// File: rtl/memory_interface.sv
// Splits cache line read/write requests into BEATS word transfers on a narrow RAM bus.
// Optional per-beat watchdog enabled by defining MI_TIMEOUT_EN.
module memory_interface #(
   parameter int unsigned LINE_ADDR_WIDTH = 12,
   parameter int unsigned LINE_WIDTH      = 64,
   parameter int unsigned BUS_WIDTH       = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 255
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       SIG_RAM_RD,
   input  logic                       SIG_RAM_WR,
   input  logic [LINE_ADDR_WIDTH-1:0] LINE_ADDR,
   input  logic [LINE_WIDTH-1:0]      MI_IN_DATA,
   output logic [LINE_WIDTH-1:0]      MI_OUT_DATA,
   output logic                       MI_SIG_RAM_ACK,
   output logic                       MI_ERR,
   memory_interface_if.master         ram
);
   localparam int unsigned BEATS     = LINE_WIDTH / BUS_WIDTH;
   localparam int unsigned BEAT_BITS = $clog2(BEATS);
   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StWrBeat  = 3'd1;
   localparam logic [2:0] StRdBeat  = 3'd2;
   localparam logic [2:0] StAck     = 3'd3;
   localparam logic [2:0] StRelease = 3'd4;

   logic [2:0]                           r_state, w_state_d;
   logic [BEAT_BITS-1:0]                 r_beat, w_beat_d;
   logic [LINE_ADDR_WIDTH-1:0]           r_line, w_line_d;
   logic [LINE_WIDTH-1:0]                r_wline, w_wline_d;
   logic [LINE_WIDTH-1:0]                r_rbuf, w_rbuf_d;
   logic [LINE_WIDTH-1:0]                r_out, w_out_d;
   logic [BUS_WIDTH-1:0]                 r_wdat, w_wdat_d;
   logic [LINE_ADDR_WIDTH+BEAT_BITS-1:0] r_addr;
   logic                                 r_ack, r_err, r_rd, r_wr;
   logic                                 w_abort, w_tmo, w_in_beat;

   assign w_in_beat = (r_state == StWrBeat) || (r_state == StRdBeat);

`ifdef MI_TIMEOUT_EN
   localparam int unsigned TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_BITS-1:0] r_tmo;

   assign w_tmo = (r_tmo == TMO_BITS'(TIMEOUT_CYCLES - 1));

   // Counter is zero whenever a beat is entered, since it idles at zero outside beat states.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_tmo <= '0;
      end else if (!w_in_beat || ram.RAM_READY || w_tmo) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= r_tmo + TMO_BITS'(1);
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_state_d = r_state;
      w_beat_d  = r_beat;
      w_line_d  = r_line;
      w_wline_d = r_wline;
      w_rbuf_d  = r_rbuf;
      w_out_d   = r_out;
      w_abort   = 1'b0;
      case (r_state)
         StIdle: begin
            // Write wins so a dirty victim is written back before the refill.
            if (SIG_RAM_WR) begin
               w_state_d = StWrBeat;
               w_beat_d  = '0;
               w_line_d  = LINE_ADDR;
               w_wline_d = MI_IN_DATA;
            end else if (SIG_RAM_RD) begin
               w_state_d = StRdBeat;
               w_beat_d  = '0;
               w_line_d  = LINE_ADDR;
            end
         end
         StWrBeat, StRdBeat: begin
            if (ram.RAM_READY) begin
               if (r_state == StRdBeat) begin
                  for (int b = 0; b < BEATS; b++) begin
                     if (r_beat == BEAT_BITS'(b)) begin
                        w_rbuf_d[b*BUS_WIDTH +: BUS_WIDTH] = ram.RAM_RDATA;
                     end
                  end
               end
               w_beat_d = r_beat + BEAT_BITS'(1);
               if (r_beat == LAST_BEAT) begin
                  w_state_d = StAck;
                  if (r_state == StRdBeat) begin
                     w_out_d = w_rbuf_d;
                  end
               end
            end else if (w_tmo) begin
               w_abort   = 1'b1;
               w_state_d = StAck;
               w_beat_d  = '0;
               if (r_state == StRdBeat) begin
                  w_out_d = '0;
               end
            end
         end
         StAck:     w_state_d = StRelease;
         StRelease: if (!SIG_RAM_RD && !SIG_RAM_WR) w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_wdat_d = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (w_beat_d == BEAT_BITS'(b)) begin
            w_wdat_d = w_wline_d[b*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

   // Bus outputs are registered from next-state values so they line up with the state.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= StIdle;
         r_beat  <= '0;
         r_line  <= '0;
         r_wline <= '0;
         r_rbuf  <= '0;
         r_out   <= '0;
         r_wdat  <= '0;
         r_addr  <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_beat  <= w_beat_d;
         r_line  <= w_line_d;
         r_wline <= w_wline_d;
         r_rbuf  <= w_rbuf_d;
         r_out   <= w_out_d;
         r_wdat  <= w_wdat_d;
         r_addr  <= {w_line_d, w_beat_d};
         r_ack   <= (w_state_d == StAck);
         r_err   <= w_abort;
         r_rd    <= (w_state_d == StRdBeat);
         r_wr    <= (w_state_d == StWrBeat);
      end
   end

   assign MI_OUT_DATA    = r_out;
   assign MI_SIG_RAM_ACK = r_ack;
   assign MI_ERR         = r_err;
   assign ram.RAM_ADDR   = r_addr;
   assign ram.RAM_RD     = r_rd;
   assign ram.RAM_WR     = r_wr;
   assign ram.RAM_WDATA  = r_wdat;
endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface; RAM model returns word = address.
module tb_memory_interface;
   localparam int unsigned LAW = 12;
   localparam int unsigned LW  = 64;
   localparam int unsigned BW  = 16;
   localparam int unsigned AW  = 14;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           sig_rd = 1'b0;
   logic           sig_wr = 1'b0;
   logic [LAW-1:0] line_addr = '0;
   logic [LW-1:0]  in_data = '0;
   logic [LW-1:0]  out_data;
   logic           ack;
   logic           err;
   int             n_tests = 0;
   int             n_fail = 0;

   memory_interface_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(BW)) u_ram_if ();

   assign u_ram_if.RAM_RDATA = BW'(u_ram_if.RAM_ADDR);

   memory_interface #(
      .LINE_ADDR_WIDTH(LAW),
      .LINE_WIDTH     (LW),
      .BUS_WIDTH      (BW),
      .TIMEOUT_CYCLES (8)
   ) u_dut (
      .CLK           (clk),
      .RESET         (rst),
      .SIG_RAM_RD    (sig_rd),
      .SIG_RAM_WR    (sig_wr),
      .LINE_ADDR     (line_addr),
      .MI_IN_DATA    (in_data),
      .MI_OUT_DATA   (out_data),
      .MI_SIG_RAM_ACK(ack),
      .MI_ERR        (err),
      .ram           (u_ram_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [LAW-1:0] la, input logic [LW-1:0] exp);
      logic [AW-1:0] base;
      base = {la, 2'b00};
      line_addr = la;
      sig_rd = 1'b1;
      u_ram_if.RAM_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rd_strobe", 64'(u_ram_if.RAM_RD), 64'd1);
         check("rd_addr", 64'(u_ram_if.RAM_ADDR), 64'(base) + 64'(i));
      end
      tick();
      check("rd_ack", 64'(ack), 64'd1);
      check("rd_err", 64'(err), 64'd0);
      check("rd_strobe_drop", 64'(u_ram_if.RAM_RD), 64'd0);
      check("rd_out", out_data, exp);
      sig_rd = 1'b0;
      tick();
      check("rd_ack_pulse", 64'(ack), 64'd0);
      tick();
   endtask

   initial begin
      logic       rdy[7];
      logic       wr_exp[7];
      logic [1:0] beat_exp[6];
      logic [15:0] wd_exp[6];
      rdy      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      wr_exp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      beat_exp = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
      wd_exp   = '{16'hAAAA, 16'hBBBB, 16'hBBBB, 16'hBBBB, 16'hCCCC, 16'hDDDD};
      u_ram_if.RAM_READY = 1'b1;

      #3;
      check("rst_out", out_data, 64'd0);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_rd", 64'(u_ram_if.RAM_RD), 64'd0);
      check("rst_wr", 64'(u_ram_if.RAM_WR), 64'd0);
      check("rst_addr", 64'(u_ram_if.RAM_ADDR), 64'd0);
      check("rst_wdata", 64'(u_ram_if.RAM_WDATA), 64'd0);
      #4 rst = 1'b0;
      tick();

      // Plain read, ready tied high
      do_read(12'h005, 64'h0017_0016_0015_0014);

      // Write with two wait cycles on beat 1
      line_addr = 12'h007;
      in_data = 64'hDDDD_CCCC_BBBB_AAAA;
      sig_wr = 1'b1;
      for (int i = 0; i < 7; i++) begin
         u_ram_if.RAM_READY = rdy[i];
         tick();
         check("wr_strobe", 64'(u_ram_if.RAM_WR), 64'(wr_exp[i]));
         check("wr_rd_low", 64'(u_ram_if.RAM_RD), 64'd0);
         check("wr_ack", 64'(ack), (i == 6) ? 64'd1 : 64'd0);
         if (i < 6) begin
            check("wr_wdata", 64'(u_ram_if.RAM_WDATA), 64'(wd_exp[i]));
            check("wr_addr", 64'(u_ram_if.RAM_ADDR), 64'({12'h007, beat_exp[i]}));
         end
      end
      check("wr_keeps_out", out_data, 64'h0017_0016_0015_0014);
      sig_wr = 1'b0;
      tick();
      check("wr_ack_pulse", 64'(ack), 64'd0);
      tick();

      // Both requests together: write first, then held high without retrigger
      line_addr = 12'h00A;
      in_data = 64'h4444_3333_2222_1111;
      sig_wr = 1'b1;
      sig_rd = 1'b1;
      u_ram_if.RAM_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("both_wr", 64'(u_ram_if.RAM_WR), 64'd1);
         check("both_no_rd", 64'(u_ram_if.RAM_RD), 64'd0);
      end
      tick();
      check("both_ack", 64'(ack), 64'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("held_quiet", 64'({u_ram_if.RAM_RD, u_ram_if.RAM_WR, ack}), 64'd0);
      end
      sig_wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rd_held_quiet", 64'({u_ram_if.RAM_RD, ack}), 64'd0);
      end
      sig_rd = 1'b0;
      tick();
      do_read(12'h00A, 64'h002B_002A_0029_0028);

      // Asynchronous reset during beat 2 of a read
      line_addr = 12'h001;
      sig_rd = 1'b1;
      tick();
      tick();
      tick();
      check("pre_rst_addr", 64'(u_ram_if.RAM_ADDR), 64'h6);
      #2 rst = 1'b1;
      #1;
      check("async_rd_drop", 64'(u_ram_if.RAM_RD), 64'd0);
      check("async_ack", 64'(ack), 64'd0);
      check("async_out", out_data, 64'd0);
      sig_rd = 1'b0;
      #2 rst = 1'b0;
      tick();
      tick();
      check("post_rst_no_ack", 64'(ack), 64'd0);
      check("post_rst_out", out_data, 64'd0);
      do_read(12'h002, 64'h000B_000A_0009_0008);

`ifdef MI_TIMEOUT_EN
      // Stuck RAM: watchdog aborts after 8 cycles in beat 0
      line_addr = 12'h003;
      sig_rd = 1'b1;
      u_ram_if.RAM_READY = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("tmo_wait_rd", 64'(u_ram_if.RAM_RD), 64'd1);
         check("tmo_wait_ack", 64'(ack), 64'd0);
      end
      tick();
      check("tmo_ack", 64'(ack), 64'd1);
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_out", out_data, 64'd0);
      sig_rd = 1'b0;
      tick();
      tick();
      u_ram_if.RAM_READY = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/memory_interface.md
# memory_interface

Bridges the cache's line-wide RAM request port to a narrow word-serial RAM bus. It sits directly downstream of the cache memory block. It accepts level-held read and write requests (SIG_RAM_RD, SIG_RAM_WR) with a full cache line, splits each line into BEATS bus transfers with a per-beat ready handshake, and reassembles read data. It then returns one MI_SIG_RAM_ACK pulse per completed line transfer.

## Interface
- LINE_ADDR_WIDTH, 12: line address width (tag+index bits of CPU address).
- LINE_WIDTH, 64: cache line width; equals c_RAM_DATA_SIZE.
- BUS_WIDTH, 16: RAM bus data width; LINE_WIDTH must be an integer multiple; BEATS = LINE_WIDTH/BUS_WIDTH, power of two, ≥2.
- TIMEOUT_CYCLES, 255: per-beat watchdog limit (only used with MI_TIMEOUT_EN).

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- SIG_RAM_RD  in  1  cache line-read request, level, held until ack.
- SIG_RAM_WR  in  1  cache line-write request, level, held until ack.
- LINE_ADDR  in  LINE_ADDR_WIDTH  line address, sampled on request accept.
- MI_IN_DATA  in  LINE_WIDTH  line to write, sampled on request accept.
- MI_OUT_DATA  out  LINE_WIDTH  assembled read line, registered.
- MI_SIG_RAM_ACK  out  1  one-cycle completion pulse.
- MI_ERR  out  1  one-cycle error pulse, coincident with ack.
- RAM_ADDR  out  LINE_ADDR_WIDTH+log2(BEATS)  word address {line, beat}.
- RAM_RD  out  1  beat read strobe.
- RAM_WR  out  1  beat write strobe.
- RAM_WDATA  out  BUS_WIDTH  beat write data.
- RAM_RDATA  in  BUS_WIDTH  beat read data, valid when RAM_READY=1.
- RAM_READY  in  1  beat completion from RAM.

## Operation
- FSM states: IDLE, WR_BEAT, RD_BEAT, ACK, RELEASE.
- IDLE: on SIG_RAM_WR=1, latch LINE_ADDR/MI_IN_DATA, beat=0, go to WR_BEAT. Otherwise, on SIG_RAM_RD=1, latch LINE_ADDR, beat=0, go to RD_BEAT. If both are high, the write wins (write-back precedes refill). The read is served after RELEASE once the cache re-requests.
- WR_BEAT: RAM_WR=1, RAM_ADDR={line,beat}, RAM_WDATA=line[beat*BUS_WIDTH +: BUS_WIDTH]. Beat 0 is the least significant slice.
- RD_BEAT: RAM_RD=1, same addressing. On RAM_READY=1, RAM_RDATA is written into slice beat of the read buffer.
- In either beat state, RAM_READY=1 completes the beat and increments beat. Completion of beat BEATS-1 goes to ACK. Otherwise the state is held with the strobe continuously asserted.
- ACK: MI_SIG_RAM_ACK=1 for exactly one cycle. For a read, MI_OUT_DATA is updated from the buffer on entry to ACK. Next state is RELEASE.
- RELEASE: wait until SIG_RAM_RD=0 and SIG_RAM_WR=0 are sampled together, then go to IDLE. This prevents a held request from re-triggering.
- MI_OUT_DATA holds its value until the next completed read; writes and errors other than timeout-read do not alter it.
- Request inputs changing mid-transfer are ignored; the latched address and data are used.

## Timing
- Reset values: state IDLE, beat 0, MI_OUT_DATA 0, MI_SIG_RAM_ACK 0, MI_ERR 0, RAM_RD 0, RAM_WR 0, RAM_ADDR 0, RAM_WDATA 0.
- All outputs are registered.
- Request sampled in IDLE at edge k: strobe and beat-0 address are visible after edge k.
- With RAM_READY tied high, a beat takes 1 cycle. The ack is high in the cycle after the last beat edge, so accept-to-ack is BEATS+1 edges.
- Each beat adds one cycle per cycle that RAM_READY is low.
- Strobes drop in ACK. Never assert RAM_RD and RAM_WR together.
- RAM_READY is ignored outside the beat states.
- RESET mid-transfer: strobes and ack drop immediately (asynchronously). The partial line is discarded, and no ack is issued for the aborted transfer.

## Configuration
- MI_TIMEOUT_EN defined: a per-beat counter clears on every beat entry and on RAM_READY. When it reaches TIMEOUT_CYCLES with RAM_READY still low, the transfer aborts and the FSM goes to ACK with MI_ERR=1 alongside MI_SIG_RAM_ACK. An aborted read sets MI_OUT_DATA to all zeros.
- MI_TIMEOUT_EN undefined: there is no counter, beats wait indefinitely, and MI_ERR is constant 0.

## Test plan
- Read with RAM_READY=1 and RAM returning word = address (LINE_ADDR=0x005): RAM_ADDR steps 0x014..0x017, ack at edge 5, MI_OUT_DATA=0x0017_0016_0015_0014.
- Write MI_IN_DATA=0xDDDD_CCCC_BBBB_AAAA with RAM_READY low for 2 cycles on beat 1: RAM_WDATA sequence AAAA, BBBB (held 3 cycles), CCCC, DDDD. A single ack pulse follows, at edge 7.
- SIG_RAM_RD and SIG_RAM_WR raised together: write beats only, ack, then RELEASE. The read is served only after both requests drop and RD is raised again.
- Request held high for 10 cycles after ack: no second transfer and no further strobes.
- RESET asserted during beat 2 of a read: RAM_RD falls without waiting for a clock edge, no ack is issued, MI_OUT_DATA is 0. A new read after reset completes normally.
- With MI_TIMEOUT_EN and TIMEOUT_CYCLES=8, read with RAM_READY stuck low: ack and MI_ERR pulse together after 8 cycles in beat 0, and MI_OUT_DATA is 0.
